// File: rtl/spectrum_peak_tracker.sv
// -----------------------------------------------------------------------------
// spectrum_peak_tracker
//
// Tracks eight 13-bit DFT bin magnitudes, one frame per mag_valid strobe.
// For every bin it keeps an exponentially smoothed level and a peak-hold value
// (held for HOLD_FRAMES frames, then decayed by DECAY per frame). It also
// reports the loudest smoothed bin of the last frame. Bins are processed one
// per clock from a snapshot taken when the strobe is accepted.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   mag[0:7]       unsigned bin magnitudes from the FFT stage
//   mag_valid      one-cycle strobe, mag holds a complete new frame
//   level[0:7]     smoothed level per bin
//   peak[0:7]      peak-hold value per bin
//   max_bin        index of the largest smoothed level in the last frame
//   max_level      smoothed level of max_bin
//   busy           high while a frame is being processed
//   frame_done     one-cycle pulse when the frame outputs are updated
//   overrun_count  saturating count of strobes dropped while busy
// -----------------------------------------------------------------------------
module spectrum_peak_tracker #(
    parameter int ALPHA_SHIFT = 2,
    parameter int HOLD_FRAMES = 16,
    parameter int DECAY       = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [12:0] mag [0:7],
    input  logic        mag_valid,
    output logic [12:0] level [0:7],
    output logic [12:0] peak [0:7],
    output logic [2:0]  max_bin,
    output logic [12:0] max_level,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  overrun_count
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_PROC   = 2'd1;
    localparam logic [1:0]  ST_DONE   = 2'd2;

    localparam logic [12:0] DECAY_W   = 13'(DECAY);
    localparam logic [7:0]  HOLD_INIT = 8'(HOLD_FRAMES);

    // Smoothed value: cur + ((tgt - cur) >>> ALPHA_SHIFT). The result always
    // lies between cur and tgt, so truncating to 13 bits never loses data.
    function automatic logic [12:0] smooth(input logic [12:0] cur,
                                           input logic [12:0] tgt);
        logic signed [13:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        return 13'($signed({1'b0, cur}) + (diff >>> ALPHA_SHIFT));
    endfunction

    // Linear decay toward the current level, guarded against underflow.
    function automatic logic [12:0] decay_peak(input logic [12:0] pk,
                                               input logic [12:0] a);
        logic [12:0] dec;
        logic [12:0] res;
        dec = pk - DECAY_W;
        if (pk < DECAY_W) begin
            res = a;
        end else if (dec > a) begin
            res = dec;
        end else begin
            res = a;
        end
        return res;
    endfunction

    logic [1:0]  state_q,      state_d;
    logic [2:0]  idx_q,        idx_d;
    logic [12:0] snap_q  [0:7];
    logic [12:0] snap_d  [0:7];
    logic [12:0] level_q [0:7];
    logic [12:0] level_d [0:7];
    logic [12:0] peak_q  [0:7];
    logic [12:0] peak_d  [0:7];
    logic [7:0]  hold_q  [0:7];
    logic [7:0]  hold_d  [0:7];
    logic [12:0] run_max_q,    run_max_d;
    logic [2:0]  run_bin_q,    run_bin_d;
    logic [2:0]  max_bin_q,    max_bin_d;
    logic [12:0] max_level_q,  max_level_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  overrun_q,    overrun_d;
    logic [12:0] avg_s;

    // Next-state logic: frame sequencing, per-bin smoothing/peak update, overrun count.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        level_d      = level_q;
        peak_d       = peak_q;
        hold_d       = hold_q;
        run_max_d    = run_max_q;
        run_bin_d    = run_bin_q;
        max_bin_d    = max_bin_q;
        max_level_d  = max_level_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        avg_s        = smooth(level_q[idx_q], snap_q[idx_q]);

        case (state_q)
            ST_IDLE: begin
                if (mag_valid) begin
                    snap_d    = mag;
                    idx_d     = 3'd0;
                    run_max_d = 13'd0;
                    run_bin_d = 3'd0;
                    state_d   = ST_PROC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_PROC: begin
                level_d[idx_q] = avg_s;
                if (avg_s >= peak_q[idx_q]) begin
                    peak_d[idx_q] = avg_s;
                    hold_d[idx_q] = HOLD_INIT;
                end else if (hold_q[idx_q] != 8'd0) begin
                    hold_d[idx_q] = hold_q[idx_q] - 8'd1;
                end else begin
                    peak_d[idx_q] = decay_peak(peak_q[idx_q], avg_s);
                end
                // Strictly greater: ties keep the lower bin index.
                if (avg_s > run_max_q) begin
                    run_max_d = avg_s;
                    run_bin_d = idx_q;
                end else begin
                    run_max_d = run_max_q;
                end
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_DONE: begin
                max_bin_d    = run_bin_q;
                max_level_d  = run_max_q;
                frame_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A strobe arriving while a frame is in flight is dropped and counted.
        if (mag_valid && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            run_max_q    <= 13'd0;
            run_bin_q    <= 3'd0;
            max_bin_q    <= 3'd0;
            max_level_q  <= 13'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                snap_q[i]  <= 13'd0;
                level_q[i] <= 13'd0;
                peak_q[i]  <= 13'd0;
                hold_q[i]  <= 8'd0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            run_max_q    <= run_max_d;
            run_bin_q    <= run_bin_d;
            max_bin_q    <= max_bin_d;
            max_level_q  <= max_level_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            snap_q       <= snap_d;
            level_q      <= level_d;
            peak_q       <= peak_d;
            hold_q       <= hold_d;
        end
    end

    assign level         = level_q;
    assign peak          = peak_q;
    assign max_bin       = max_bin_q;
    assign max_level     = max_level_q;
    assign frame_done    = frame_done_q;
    assign overrun_count = overrun_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spectrum_peak_tracker.sv
// -----------------------------------------------------------------------------
// tb_spectrum_peak_tracker
//
// Two instances share one stimulus stream: u_a smooths with ALPHA_SHIFT = 2,
// u_b with ALPHA_SHIFT = 0 (level follows mag). Expected frame results are
// pushed to a queue when a strobe is driven and popped when frame_done fires.
// -----------------------------------------------------------------------------
module tb_spectrum_peak_tracker;

    typedef logic [12:0] frame_t [0:7];

    typedef struct {
        bit          chk_a;
        int          a_bin;
        logic [12:0] a_lvl;
        logic [2:0]  a_mb;
        logic [12:0] a_ml;
        int          b_bin;
        logic [12:0] b_lvl;
        logic [12:0] b_pk;
        logic [2:0]  b_mb;
        logic [12:0] b_ml;
        int          x_bin;
        logic [12:0] x_pk;
    } exp_t;

    typedef struct {
        frame_t m;
        exp_t   e;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [12:0] mag [0:7];
    logic        mag_valid;

    logic [12:0] lvl_a [0:7];
    logic [12:0] pk_a  [0:7];
    logic [2:0]  mb_a;
    logic [12:0] ml_a;
    logic        busy_a, fd_a;
    logic [7:0]  ovr_a;

    logic [12:0] lvl_b [0:7];
    logic [12:0] pk_b  [0:7];
    logic [2:0]  mb_b;
    logic [12:0] ml_b;
    logic        busy_b, fd_b;
    logic [7:0]  ovr_b;

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    spectrum_peak_tracker #(.ALPHA_SHIFT(2), .HOLD_FRAMES(16), .DECAY(8)) u_a (
        .clk(clk), .reset_n(reset_n), .mag(mag), .mag_valid(mag_valid),
        .level(lvl_a), .peak(pk_a), .max_bin(mb_a), .max_level(ml_a),
        .busy(busy_a), .frame_done(fd_a), .overrun_count(ovr_a)
    );

    spectrum_peak_tracker #(.ALPHA_SHIFT(0), .HOLD_FRAMES(16), .DECAY(8)) u_b (
        .clk(clk), .reset_n(reset_n), .mag(mag), .mag_valid(mag_valid),
        .level(lvl_b), .peak(pk_b), .max_bin(mb_b), .max_level(ml_b),
        .busy(busy_b), .frame_done(fd_b), .overrun_count(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input bit ca, input int ab, input int al, input int amb,
                                    input int aml, input int bb, input int bl, input int bp,
                                    input int bmb, input int bml, input int xb, input int xp);
        exp_t e;
        e.chk_a = ca;            e.a_bin = ab;          e.a_lvl = 13'(al);
        e.a_mb  = 3'(amb);       e.a_ml  = 13'(aml);    e.b_bin = bb;
        e.b_lvl = 13'(bl);       e.b_pk  = 13'(bp);     e.b_mb  = 3'(bmb);
        e.b_ml  = 13'(bml);      e.x_bin = xb;          e.x_pk  = 13'(xp);
        return e;
    endfunction

    // Drive one strobe, optionally scrambling mag and re-pulsing mag_valid at
    // cycles 3 and 9, then wait (bounded) for frame_done and score the result.
    task automatic run_frame(input frame_t m, input exp_t e_in, input bit noise);
        int   cyc;
        bit   seen;
        exp_t e;
        @(negedge clk);
        mag       = m;
        mag_valid = 1'b1;
        sb.push_back(e_in);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (noise) begin
                for (int i = 0; i < 8; i++) mag[i] = 13'($urandom_range(0, 8191));
                mag_valid = (cyc == 3 || cyc == 9);
            end else begin
                mag_valid = 1'b0;
            end
            if (fd_a || fd_b) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk("frame_done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", cyc, 10);
            chk("fd_b", fd_b, 1);
            chk("busy_at_done", busy_a, 0);
            if (e.chk_a) begin
                chk("a_level", lvl_a[e.a_bin], e.a_lvl);
                chk("a_max_bin", mb_a, e.a_mb);
                chk("a_max_level", ml_a, e.a_ml);
            end
            chk("b_level", lvl_b[e.b_bin], e.b_lvl);
            chk("b_peak", pk_b[e.b_bin], e.b_pk);
            chk("b_max_bin", mb_b, e.b_mb);
            chk("b_max_level", ml_b, e.b_ml);
            chk("b_peak_x", pk_b[e.x_bin], e.x_pk);
        end
    endtask

    initial begin
        vec_t   vecs [5];
        frame_t f;
        frame_t zero;
        int     stray;
        int     k;

        zero = '{default: 13'd0};

        // Smoothing convergence on bin 3, then the tie-break pair on bins 2/6.
        f = zero; f[3] = 13'd4000;
        vecs[0].m = f; vecs[0].e = mk_exp(1, 3, 1000, 3, 1000, 3, 4000, 4000, 3, 4000, 3, 4000);
        vecs[1].m = f; vecs[1].e = mk_exp(1, 3, 1750, 3, 1750, 3, 4000, 4000, 3, 4000, 3, 4000);
        vecs[2].m = f; vecs[2].e = mk_exp(1, 3, 2312, 3, 2312, 3, 4000, 4000, 3, 4000, 3, 4000);
        f = zero; f[2] = 13'd500; f[6] = 13'd500;
        vecs[3].m = f; vecs[3].e = mk_exp(1, 2, 125, 3, 1734, 2, 500, 500, 2, 500, 3, 4000);
        f[6] = 13'd501;
        vecs[4].m = f; vecs[4].e = mk_exp(1, 6, 219, 3, 1300, 6, 501, 501, 6, 501, 3, 4000);

        reset_n   = 1'b0;
        mag_valid = 1'b0;
        mag       = zero;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_fd", fd_a, 0);
        chk("rst_max_bin", mb_b, 0);
        chk("rst_max_level", ml_b, 0);
        chk("rst_overrun", ovr_b, 0);
        for (int i = 0; i < 8; i++) begin
            chk("rst_level", lvl_b[i], 0);
            chk("rst_peak", pk_a[i], 0);
        end
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_frame(vecs[i].m, vecs[i].e, 1'b0);

        // Dropped re-pulses and scrambled mag during processing.
        f = zero; f[1] = 13'd800;
        run_frame(f, mk_exp(1, 1, 200, 3, 975, 1, 800, 800, 1, 800, 3, 4000), 1'b1);
        chk("overrun_a", ovr_a, 2);
        chk("overrun_b", ovr_b, 2);
        @(negedge clk);
        chk("fd_pulse_width", fd_a, 0);

        // Peak hold and decay on bin 5; underflow guard on bin 4.
        f = zero; f[5] = 13'd1000; f[4] = 13'd5;
        run_frame(f, mk_exp(0, 0, 0, 0, 0, 5, 1000, 1000, 5, 1000, 4, 5), 1'b0);
        for (k = 1; k <= 18; k++) begin
            run_frame(zero,
                      mk_exp(0, 0, 0, 0, 0, 5, 0,
                             (k <= 16) ? 1000 : 1000 - 8 * (k - 16),
                             0, 0, 4, (k <= 16) ? 5 : 0),
                      1'b0);
        end

        // Back-to-back strobes saturate the overrun counter.
        @(negedge clk);
        mag       = zero;
        mag_valid = 1'b1;
        repeat (300) @(negedge clk);
        mag_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("overrun_sat_a", ovr_a, 255);
        chk("overrun_sat_b", ovr_b, 255);

        // Reset in the middle of a frame, asserted together with a strobe.
        f = '{default: 13'd3000};
        @(negedge clk);
        mag       = f;
        mag_valid = 1'b1;
        @(negedge clk);
        mag_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n   = 1'b0;
        mag_valid = 1'b1;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_level0", lvl_b[0], 0);
        chk("midrst_peak0", pk_b[0], 0);
        chk("midrst_overrun", ovr_b, 0);
        @(negedge clk);
        @(negedge clk);
        mag_valid = 1'b0;
        reset_n   = 1'b1;
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            if (fd_a || fd_b || busy_a || busy_b) stray++;
        end
        chk("no_frame_after_reset", stray, 0);

        f = zero; f[0] = 13'd100;
        run_frame(f, mk_exp(1, 0, 25, 0, 25, 0, 100, 100, 0, 100, 0, 100), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spectrum_peak_tracker.md
Name: spectrum_peak_tracker

Overview:
Consumes the eight 13-bit DFT bin magnitudes produced by the FFT interface stage, one frame per valid strobe. Per bin it keeps:
- an exponentially smoothed level;
- a peak-hold value with hold timer and linear decay.

It also reports the loudest smoothed bin. It sits between the FFT/magnitude stage and the display/LED drivers, and processes one bin per clock through a small state machine.

Parameters:
ALPHA_SHIFT, 2, smoothing shift: avg += (mag - avg) >>> ALPHA_SHIFT; 0 means avg = mag.
HOLD_FRAMES, 16, frames a new peak is held before decay starts (8-bit range, 0..255).
DECAY, 8, amount subtracted from a peak per frame once its hold expires.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
mag  input  [12:0] x [0:7]  bin magnitudes from the FFT stage, unsigned
mag_valid  input  1  one-cycle strobe: mag holds a complete new frame
level  output  [12:0] x [0:7]  smoothed level per bin
peak  output  [12:0] x [0:7]  peak-hold value per bin
max_bin  output  3  index of the largest smoothed level in the last frame
max_level  output  13  smoothed level of max_bin
busy  output  1  high while a frame is being processed
frame_done  output  1  one-cycle pulse when outputs for a frame are updated
overrun_count  output  8  saturating count of mag_valid strobes dropped while busy

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset clears everything to 0: all level, peak, max_bin, max_level, frame_done, overrun_count, the internal hold counters and the snapshot. State returns to IDLE and busy = 0.
- Reset mid-frame abandons the frame. No frame_done follows it.

States: IDLE -> PROC -> DONE -> IDLE.
- busy = (state != IDLE), decoded from the state register.

IDLE:
- On the edge where mag_valid = 1 (edge E0), copy all 8 mag words into an internal snapshot.
- Set idx = 0, clear the running max (value 0, index 0), go to PROC.
- Later changes on mag do not affect the frame in progress.

PROC (edges E1..E8, bin idx = 0..7, one bin per edge):
- Smoothing:
  - diff = snap[idx] - level[idx], 14-bit signed.
  - a = level[idx] + (diff >>> ALPHA_SHIFT), arithmetic shift (floor).
  - Result always lies in [min(snap, level), max(snap, level)]. No saturation needed; the result is stored in 13 bits.
- Peak update:
  - If a >= peak[idx]: peak = a, hold = HOLD_FRAMES.
  - Else if hold > 0: hold decrements, peak unchanged.
  - Else: peak = max(peak - DECAY, a). The subtraction is underflow-guarded: if peak < DECAY, use a.
- Max tracking:
  - Replace the running max only if a is strictly greater than it, so ties keep the lower index.
  - All-zero frame gives max_bin = 0, max_level = 0.
- level[idx] and peak[idx] update at their own edge; other bins hold their values.
- After idx = 7, go to DONE.

DONE (edge E9):
- max_bin and max_level are loaded from the running max.
- frame_done = 1 for exactly the cycle after E9.
- Go to IDLE, so busy = 0 after E9.

Timing:
- A new frame is accepted at E10 at the earliest, i.e. mag_valid must be 10 cycles after the previous accepted strobe.
- Latency from accepted strobe to frame_done = 10 cycles.

Overrun:
- mag_valid while state != IDLE is dropped; overrun_count increments, saturating at 255.
- mag_valid together with reset assertion: reset wins.

Test Plan:
1. Assert reset_n = 0 mid-run, then release -> all outputs 0, busy 0; no frame_done until the next mag_valid.
2. ALPHA_SHIFT = 2; mag[3] = 4000, others 0, three frames 10 cycles apart -> level[3] = 1000, 1750, 2312; max_bin = 3; max_level matches level[3]; frame_done exactly 10 cycles after each strobe.
3. ALPHA_SHIFT = 0, HOLD_FRAMES = 16, DECAY = 8; one frame with mag[5] = 1000, then frames with all zero -> peak[5] = 1000 for the next 16 frames, then 992, 984, …; level[5] = 0 from the second frame.
4. Tie: mag[2] = mag[6] = 500, ALPHA_SHIFT = 0 -> max_bin = 2, max_level = 500. Then mag[6] = 501 -> max_bin = 6.
5. mag_valid re-pulsed at cycles 3 and 9 after an accepted strobe -> both dropped, overrun_count = 2, frame outputs use the first snapshot. 300 back-to-back strobes -> overrun_count saturates at 255.
6. Change mag every cycle during PROC -> results reflect only the E0 snapshot. Underflow check: peak = 5 with hold expired and a = 0 -> peak becomes 0, not a wrapped value.
